// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    // Per-channel supervisor states
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        READY     = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    // Width of the shared per-channel counter. It only ever counts up to
    // (largest cycle parameter - 1), so $clog2 of the largest one is enough.
    function automatic int cnt_width(input int rst_cycles,
                                     input int stable_cycles,
                                     input int timeout_cycles);
        int m;
        m = rst_cycles;
        if (stable_cycles > m)  m = stable_cycles;
        if (timeout_cycles > m) m = timeout_cycles;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_fsm.sv
// Single-channel PLL supervisor: locked synchroniser, reset/lock FSM,
// timeout/retry handling and lock-loss counter.
// Loss counter is built only when PLL_SUP_LOSS_COUNT_EN is defined;
// otherwise loss_count is tied to zero.
module pll_lock_fsm #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 4,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  force_relock,
    output logic                  pll_rst,
    output logic                  clk_ready,
    output logic                  pll_fail,
    output logic [LOSS_CNT_W-1:0] loss_count
);
    import pll_sup_pkg::*;

    localparam int CNT_W   = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                       LOCK_TIMEOUT_CYCLES);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic               sync_p0;
    logic               sync_p1;
    pll_state_e         state_q;
    pll_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic [RETRY_W-1:0] retry_inc;

    assign retry_inc = retry_q + RETRY_W'(1);

    // Two-flop synchroniser for the asynchronous locked input
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pll_locked;
            sync_p1 <= sync_p0;
        end
    end

    // State, shared counter and retry registers
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Next-state logic; the counter restarts at zero on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        if (force_relock) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (sync_p1) begin
                        state_d = STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d   = '0;
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? FAIL : RESET_PLL;
                    end
                end
                STABILIZE: begin
                    if (!sync_p1) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = READY;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                READY: begin
                    cnt_d = '0;
                    if (!sync_p1) begin
                        state_d = RESET_PLL;
                    end
                end
                FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Registered outputs, aligned with the state register
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst   <= 1'b1;
            clk_ready <= 1'b0;
            pll_fail  <= 1'b0;
        end else begin
            pll_rst   <= (state_d == RESET_PLL) || (state_d == FAIL);
            clk_ready <= (state_d == READY);
            pll_fail  <= (state_d == FAIL);
        end
    end

`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;
    logic                  loss_evt;

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (&v) ? v : v + LOSS_CNT_W'(1);
    endfunction

    // A forced relock takes priority, so a coincident drop is not counted
    assign loss_evt = (state_q == READY) && !sync_p1 && !force_relock;

    // Saturating lock-loss counter
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_evt) begin
            loss_q <= sat_inc(loss_q);
        end
    end

    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// Top-level PLL lock supervisor: one pll_lock_fsm per PLL plus the
// registered aggregate ready flag.
// Optional macro PLL_SUP_LOSS_COUNT_EN enables the lock-loss counters.
module pll_lock_supervisor #(
    parameter int NUM_PLLS            = 1,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 4,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                           refclk,
    input  logic                           rst,
    input  logic [NUM_PLLS-1:0]            pll_locked,
    input  logic [NUM_PLLS-1:0]            force_relock,
    output logic [NUM_PLLS-1:0]            pll_rst,
    output logic [NUM_PLLS-1:0]            clk_ready,
    output logic                           all_ready,
    output logic [NUM_PLLS-1:0]            pll_fail,
    output logic [NUM_PLLS*LOSS_CNT_W-1:0] lock_loss_count
);

    for (genvar i = 0; i < NUM_PLLS; i++) begin : g_chan
        pll_lock_fsm #(
            .RST_PULSE_CYCLES    (RST_PULSE_CYCLES),
            .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
            .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
            .MAX_RETRIES         (MAX_RETRIES),
            .LOSS_CNT_W          (LOSS_CNT_W)
        ) u_fsm (
            .refclk       (refclk),
            .rst          (rst),
            .pll_locked   (pll_locked[i]),
            .force_relock (force_relock[i]),
            .pll_rst      (pll_rst[i]),
            .clk_ready    (clk_ready[i]),
            .pll_fail     (pll_fail[i]),
            .loss_count   (lock_loss_count[i*LOSS_CNT_W +: LOSS_CNT_W])
        );
    end

    // Aggregate ready, one cycle behind the per-channel flags
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            all_ready <= 1'b0;
        end else begin
            all_ready <= &clk_ready;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor (NUM_PLLS=2, short timings).
module tb_pll_lock_supervisor;

`ifdef PLL_SUP_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       refclk;
    logic       rst;
    logic [1:0] pll_locked;
    logic [1:0] force_relock;
    logic [1:0] pll_rst, clk_ready, pll_fail;
    logic       all_ready;
    logic [15:0] lock_loss_count;
    logic [1:0] pll_rst_w2, clk_ready_w2, pll_fail_w2;
    logic       all_ready_w2;
    logic [3:0] lock_loss_count_w2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pll_lock_supervisor #(
        .NUM_PLLS(2), .RST_PULSE_CYCLES(4), .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2), .LOSS_CNT_W(8)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .force_relock(force_relock), .pll_rst(pll_rst), .clk_ready(clk_ready),
        .all_ready(all_ready), .pll_fail(pll_fail), .lock_loss_count(lock_loss_count)
    );

    pll_lock_supervisor #(
        .NUM_PLLS(2), .RST_PULSE_CYCLES(4), .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2), .LOSS_CNT_W(2)
    ) dut_w2 (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .force_relock(force_relock), .pll_rst(pll_rst_w2), .clk_ready(clk_ready_w2),
        .all_ready(all_ready_w2), .pll_fail(pll_fail_w2), .lock_loss_count(lock_loss_count_w2)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    // Hold reset for two edges, release just after an edge; next edge is cycle 1
    task automatic do_reset();
        rst = 1'b1;
        force_relock = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_rst;
        rst = 1'b1;
        pll_locked = 2'b00;
        force_relock = 2'b00;
        tick();
        tick();
        checks++;
        if (pll_rst !== 2'b11 || clk_ready !== 2'b00 || all_ready !== 1'b0 ||
            pll_fail !== 2'b00 || lock_loss_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: pll_rst=%b clk_ready=%b all_ready=%b pll_fail=%b loss=%h, expected 11 00 0 00 0000",
                     pll_rst, clk_ready, all_ready, pll_fail, lock_loss_count);
        end
        checks++;
        if (pll_rst_w2 !== 2'b11 || clk_ready_w2 !== 2'b00 || all_ready_w2 !== 1'b0 ||
            pll_fail_w2 !== 2'b00 || lock_loss_count_w2 !== 4'h0) begin
            errors++;
            $display("FAIL reset_values_w2: pll_rst=%b clk_ready=%b all_ready=%b pll_fail=%b loss=%h, expected 11 00 0 00 0",
                     pll_rst_w2, clk_ready_w2, all_ready_w2, pll_fail_w2, lock_loss_count_w2);
        end
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_rst = (c <= 3) ? 2'b11 : 2'b00;
            checks++;
            if (pll_rst !== exp_rst) begin
                errors++;
                $display("FAIL reset_pulse cyc%0d: pll_rst=%b expected %b", c, pll_rst, exp_rst);
            end
        end
    endtask

    task automatic test_clean_lock();
        logic [4:0] got, exp;
        pll_locked = 2'b00;
        do_reset();
        for (int c = 1; c <= 44; c++) begin
            if (cyc == 9)  pll_locked[0] = 1'b1;
            if (cyc == 24) pll_locked[1] = 1'b1;
            if (cyc == 40) pll_locked[0] = 1'b0;
            tick();
            exp[4]   = (c >= 36) && (c < 44);
            exp[3]   = (c >= 35);
            exp[2]   = (c >= 20) && (c < 43);
            exp[1]   = (c <= 3);
            exp[0]   = (c <= 3) || (c >= 43);
            got = {all_ready, clk_ready, pll_rst};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_lock cyc%0d: {all_ready,clk_ready,pll_rst}=%b expected %b", c, got, exp);
            end
        end
        checks++;
        if (lock_loss_count[7:0] !== (LOSS_EN ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL clean_lock_loss: count=%0d expected %0d", lock_loss_count[7:0], LOSS_EN ? 1 : 0);
        end
    endtask

    task automatic test_glitch();
        logic exp_ready, exp_rst;
        pll_locked = 2'b00;
        do_reset();
        for (int c = 1; c <= 28; c++) begin
            if (cyc == 9)  pll_locked[0] = 1'b1;
            if (cyc == 14) pll_locked[0] = 1'b0;
            if (cyc == 15) pll_locked[0] = 1'b1;
            tick();
            exp_ready = (c >= 26);
            exp_rst   = (c <= 3);
            checks++;
            if (clk_ready[0] !== exp_ready || pll_rst[0] !== exp_rst) begin
                errors++;
                $display("FAIL glitch cyc%0d: clk_ready0=%b pll_rst0=%b expected %b %b",
                         c, clk_ready[0], pll_rst[0], exp_ready, exp_rst);
            end
        end
        checks++;
        if (lock_loss_count[7:0] !== 8'd0) begin
            errors++;
            $display("FAIL glitch_loss: count=%0d expected 0", lock_loss_count[7:0]);
        end
    endtask

    task automatic test_timeout_fail();
        logic exp_rst, exp_fail;
        pll_locked = 2'b00;
        do_reset();
        for (int c = 1; c <= 80; c++) begin
            tick();
            exp_rst  = (c <= 3) || (c >= 36 && c <= 39) || (c >= 72);
            exp_fail = (c >= 72);
            checks++;
            if (pll_rst[0] !== exp_rst || pll_fail[0] !== exp_fail) begin
                errors++;
                $display("FAIL timeout cyc%0d: pll_rst0=%b pll_fail0=%b expected %b %b",
                         c, pll_rst[0], pll_fail[0], exp_rst, exp_fail);
            end
        end
        force_relock = 2'b01;
        tick();
        force_relock = 2'b00;
        checks++;
        if (pll_fail !== 2'b10 || pll_rst !== 2'b11) begin
            errors++;
            $display("FAIL force_from_fail: pll_fail=%b pll_rst=%b expected 10 11", pll_fail, pll_rst);
        end
        while (cyc < 84) tick();
        checks++;
        if (pll_rst[0] !== 1'b1) begin
            errors++;
            $display("FAIL force_pulse_end: pll_rst0=%b expected 1", pll_rst[0]);
        end
        tick();
        checks++;
        if (pll_rst[0] !== 1'b0 || pll_fail !== 2'b10) begin
            errors++;
            $display("FAIL force_wait_lock: pll_rst0=%b pll_fail=%b expected 0 10", pll_rst[0], pll_fail);
        end
    endtask

    task automatic test_loss_in_ready();
        int nl;
        logic in_rst, in_down;
        logic [7:0] exp8;
        logic [1:0] exp2;
        pll_locked = 2'b10;
        do_reset();
        for (int c = 1; c <= 100; c++) begin
            if (cyc >= 20 && cyc <= 80 && (cyc % 20) == 0) pll_locked[1] = 1'b0;
            if (cyc >= 23 && cyc <= 83 && ((cyc - 3) % 20) == 0) pll_locked[1] = 1'b1;
            tick();
            nl = 0;
            in_rst = (c <= 3);
            in_down = (c < 13);
            for (int k = 0; k < 4; k++) begin
                if (c >= 20*k + 23) nl++;
                if (c >= 20*k + 23 && c <= 20*k + 26) in_rst = 1'b1;
                if (c >= 20*k + 23 && c <= 20*k + 35) in_down = 1'b1;
            end
            exp8 = LOSS_EN ? 8'(nl) : 8'd0;
            exp2 = LOSS_EN ? ((nl > 3) ? 2'd3 : 2'(nl)) : 2'd0;
            checks++;
            if (pll_rst[1] !== in_rst || clk_ready[1] !== !in_down ||
                lock_loss_count[15:8] !== exp8 || lock_loss_count_w2[3:2] !== exp2 ||
                lock_loss_count[7:0] !== 8'd0) begin
                errors++;
                $display("FAIL loss cyc%0d: pll_rst1=%b clk_ready1=%b cnt8=%0d cnt2=%0d cnt_ch0=%0d expected %b %b %0d %0d 0",
                         c, pll_rst[1], clk_ready[1], lock_loss_count[15:8], lock_loss_count_w2[3:2],
                         lock_loss_count[7:0], in_rst, !in_down, exp8, exp2);
            end
        end
    endtask

    task automatic test_force_with_loss();
        logic exp_ready, exp_rst;
        pll_locked = 2'b10;
        do_reset();
        for (int c = 1; c <= 38; c++) begin
            if (cyc == 20) pll_locked[1] = 1'b0;
            if (cyc == 22) force_relock = 2'b10;
            if (cyc == 23) begin
                force_relock  = 2'b00;
                pll_locked[1] = 1'b1;
            end
            tick();
            exp_ready = ((c >= 13) && (c < 23)) || (c >= 36);
            exp_rst   = (c <= 3) || (c >= 23 && c <= 26);
            checks++;
            if (clk_ready[1] !== exp_ready || pll_rst[1] !== exp_rst ||
                lock_loss_count[15:8] !== 8'd0 || lock_loss_count_w2[3:2] !== 2'd0) begin
                errors++;
                $display("FAIL force_loss cyc%0d: clk_ready1=%b pll_rst1=%b cnt8=%0d cnt2=%0d expected %b %b 0 0",
                         c, clk_ready[1], pll_rst[1], lock_loss_count[15:8], lock_loss_count_w2[3:2],
                         exp_ready, exp_rst);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] got, exp;
        pll_locked = 2'b10;
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            if (cyc == 10) pll_locked[0] = 1'b1;
            tick();
        end
        checks++;
        if (clk_ready !== 2'b10 || pll_rst !== 2'b00) begin
            errors++;
            $display("FAIL async_pre: clk_ready=%b pll_rst=%b expected 10 00", clk_ready, pll_rst);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pll_rst !== 2'b11 || clk_ready !== 2'b00 || all_ready !== 1'b0 || pll_fail !== 2'b00) begin
            errors++;
            $display("FAIL async_assert: pll_rst=%b clk_ready=%b all_ready=%b pll_fail=%b expected 11 00 0 00",
                     pll_rst, clk_ready, all_ready, pll_fail);
        end
        tick();
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp[4]   = (c >= 14);
            exp[3:2] = (c >= 13) ? 2'b11 : 2'b00;
            exp[1:0] = (c <= 3) ? 2'b11 : 2'b00;
            got = {all_ready, clk_ready, pll_rst};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_restart cyc%0d: {all_ready,clk_ready,pll_rst}=%b expected %b", c, got, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 2'b00;
        force_relock = 2'b00;
        test_reset();
        test_clean_lock();
        test_glitch();
        test_timeout_fail();
        test_loss_in_ready();
        test_force_with_loss();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Parametrised supervisor for one or more PLL instances in the refclk domain.
- Drives each PLL's reset, synchronises and debounces its locked output, and retries on lock timeout.
- Publishes per-PLL and aggregate clock-ready status, and counts lock-loss events.
- Sits beside PLL wrappers (e.g. 25 MHz to 37.5 MHz) and gates downstream SATA/link resets.

Parameters:
- NUM_PLLS, 1: number of supervised PLLs (1..8).
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per reset attempt (>=2).
- LOCK_STABLE_CYCLES, 1024: consecutive synced-locked cycles required before ready.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a retry.
- MAX_RETRIES, 4: consecutive timeouts before FAIL (>=1).
- LOSS_CNT_W, 8: width of each lock-loss counter.

Ports:
- refclk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  NUM_PLLS  raw PLL locked outputs; asynchronous to refclk.
- force_relock  in  NUM_PLLS  synchronous one-cycle request to restart that channel.
- pll_rst  out  NUM_PLLS  reset to each PLL, active-high.
- clk_ready  out  NUM_PLLS  channel in READY.
- all_ready  out  1  AND of clk_ready, registered.
- pll_fail  out  NUM_PLLS  channel in FAIL.
- lock_loss_count  out  NUM_PLLS*LOSS_CNT_W  per-channel loss counters; channel i at [i*W +: W].

Behaviour:
- Reset values while rst is high:
  - pll_rst all ones (asserted asynchronously).
  - clk_ready, all_ready, pll_fail, lock_loss_count all zero.
  - Synchronisers zero; all FSMs in RESET_PLL with counters zero.
- Each pll_locked bit passes through a 2-flop synchroniser (2-cycle latency) giving lk_s.
- Per-channel FSM, one shared counter cnt:
  - RESET_PLL:
    - pll_rst=1 for exactly RST_PULSE_CYCLES cycles, counted from rst release or from state entry.
    - Then go to WAIT_LOCK with cnt=0.
  - WAIT_LOCK:
    - pll_rst=0.
    - lk_s=1: go to STABILIZE with cnt=0.
    - cnt reaches LOCK_TIMEOUT_CYCLES-1 with lk_s=0: retry++.
    - If retry==MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
  - STABILIZE:
    - lk_s=0 on any cycle: go to WAIT_LOCK with cnt=0; the timeout restarts, retry is unchanged.
    - LOCK_STABLE_CYCLES consecutive lk_s=1 cycles: go to READY and clear retry.
  - READY:
    - clk_ready=1, registered from state.
    - lk_s=0: go to RESET_PLL, lock_loss_count++ (saturating at all ones); clk_ready drops the next cycle.
  - FAIL:
    - pll_fail=1, pll_rst=1 (PLL parked).
    - Leaves only via force_relock or rst.
- force_relock[i], from any state:
  - Next state RESET_PLL; cnt and retry cleared.
  - No loss count increment, even when it coincides with a lock drop in READY (force wins).
- all_ready is registered, 1 cycle after the last clk_ready rises; it falls 1 cycle after any clk_ready falls.
- Counter width is $clog2 of the largest of the cycle parameters. Comparisons are exact; no wrap is possible.
- Channels are fully independent; no shared state except all_ready.

Optional Feature:
- Macro PLL_SUP_LOSS_COUNT_EN.
- Defined: lock_loss_count counters are implemented as above.
- Undefined: no counter flops are built; lock_loss_count is tied to zero; port list is unchanged.

Decomposition:
- Package pll_sup_pkg holds:
  - state enum (RESET_PLL, WAIT_LOCK, STABILIZE, READY, FAIL), 3-bit encoding;
  - a function returning counter width from the parameters.
- Sub-module pll_lock_fsm: single channel (synchroniser, FSM, counter, retry, loss counter).
- Top module: a generate loop of NUM_PLLS instances plus the all_ready register.

Test Plan:
All scenarios use NUM_PLLS=2, RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Reset and clean lock:
   - Stimulus: release rst; raise locked[0] at cycle 10.
   - Response: pll_rst[0] high for cycles 0-3; clk_ready[0] rises at cycle 20 (2 sync + 8 stable); all_ready stays 0 until channel 1 is ready.
2. Glitch during STABILIZE:
   - Stimulus: locked high 5 cycles, low 1 cycle, then high.
   - Response: clk_ready waits for 8 fresh consecutive cycles; no pll_rst pulse; loss count 0.
3. Timeout and retry to FAIL:
   - Stimulus: locked held low.
   - Response: pll_rst pulses twice (4 cycles each, 32-cycle gaps); then pll_fail=1 and pll_rst stays 1.
   - Follow-up: force_relock restarts the channel and pll_fail drops the next cycle.
4. Loss in READY:
   - Stimulus: drop locked[1] for 3 cycles, 4 times.
   - Response: each drop causes a 4-cycle pll_rst pulse; count reads 4.
   - With LOSS_CNT_W=2, count saturates at 3.
5. Simultaneous force_relock and lock loss in READY:
   - Response: RESET_PLL entered; loss count unchanged.
6. Asynchronous rst mid-STABILIZE:
   - Response: outputs return to reset values immediately, before the next edge; the sequence restarts from RESET_PLL.
   - With the macro undefined, lock_loss_count stays 0 throughout scenario 4.
